calc_exec: RTL and testbench

CALC_EXEC -- requirements
Module: calc_exec

---
 rtl/calc_exec.sv | 155 +++++++++++++++
 tb/tb_calc_exec.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/calc_exec.sv
// Sequenced arithmetic unit: add/sub complete in one step, mul/div iterate
// one bit per cycle, and the result is presented as a single write to a
// downstream store (func_out nonzero), which otherwise reads recall_addr.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for start; addr_out follows recall_addr (store reads)
// S_RUN   | W shift-add / restoring-divide iterations
// S_WRITE | one-cycle write pulse: done, func_out = op+1, addr_out = op
module calc_exec #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [1:0]     op,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic [1:0]     recall_addr,
  output logic [2*W-1:0] result_out,
  output logic [2:0]     func_out,
  output logic [1:0]     addr_out,
  output logic           busy,
  output logic           done,
  output logic           err
);

  localparam int CW = $clog2(W) + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_WRITE} state_t;

  state_t         state_q, state_d;
  logic [1:0]     op_q, op_d;
  logic [W-1:0]   b_q, b_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic [2*W-1:0] mc_q, mc_d;
  // mul: multiplier shifting right; div: dividend shifting out, quotient in
  logic [W-1:0]   sh_q, sh_d;
  logic [W-1:0]   rem_q, rem_d;
  logic [2*W-1:0] result_q, result_d;
  logic           err_q, err_d;

  logic [2*W-1:0] mul_acc_nx;
  logic [2*W-1:0] mul_mc_nx;
  logic [W-1:0]   mul_sh_nx;
  logic [W:0]     div_shift;
  logic [W-1:0]   div_diff;
  logic           div_ge;
  logic [W-1:0]   div_rem_nx;
  logic [W-1:0]   div_quo_nx;

  // One iteration of shift-add multiply and restoring divide.
  // With b = 0 the trial subtract always succeeds, which naturally yields
  // quotient all ones and remainder = a.
  always_comb begin
    mul_acc_nx = acc_q + (sh_q[0] ? mc_q : '0);
    mul_mc_nx  = mc_q << 1;
    mul_sh_nx  = sh_q >> 1;
    div_shift  = {rem_q, sh_q[W-1]};
    div_ge     = (div_shift >= {1'b0, b_q});
    div_diff   = div_shift[W-1:0] - b_q;
    div_rem_nx = div_ge ? div_diff : div_shift[W-1:0];
    div_quo_nx = {sh_q[W-2:0], div_ge};
  end

  // Next-state and datapath register updates.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mc_d     = mc_q;
    sh_d     = sh_q;
    rem_d    = rem_q;
    result_d = result_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d  = op;
          b_d   = b;
          err_d = 1'b0;
          cnt_d = CW'(W - 1);
          acc_d = '0;
          mc_d  = {{W{1'b0}}, a};
          sh_d  = op[0] ? a : b;
          rem_d = '0;
          if (!op[1]) begin
            state_d  = S_WRITE;
            result_d = op[0] ? ({{W{1'b0}}, a} - {{W{1'b0}}, b})
                             : ({{W{1'b0}}, a} + {{W{1'b0}}, b});
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (op_q[0]) begin
          sh_d  = div_quo_nx;
          rem_d = div_rem_nx;
        end else begin
          acc_d = mul_acc_nx;
          mc_d  = mul_mc_nx;
          sh_d  = mul_sh_nx;
        end
        if (cnt_q == '0) begin
          state_d  = S_WRITE;
          result_d = op_q[0] ? {div_rem_nx, div_quo_nx} : mul_acc_nx;
          err_d    = op_q[0] && (b_q == '0);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_WRITE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mc_q     <= '0;
      sh_q     <= '0;
      rem_q    <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mc_q     <= mc_d;
      sh_q     <= sh_d;
      rem_q    <= rem_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_WRITE);
  assign func_out   = done ? ({1'b0, op_q} + 3'd1) : 3'd0;
  assign addr_out   = done ? op_q : recall_addr;
  assign result_out = result_q;
  assign err        = err_q;

endmodule

// File: tb/tb_calc_exec.sv
// Bench for calc_exec: a cycle-numbered behavioural model (results from plain
// arithmetic, timing from absolute write-cycle numbers) checked every cycle,
// plus directed cases with literal expectations and a randomized phase.
module tb_calc_exec;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst, start;
  logic [1:0]     op, recall_addr;
  logic [W-1:0]   a, b;
  logic [2*W-1:0] result_out;
  logic [2:0]     func_out;
  logic [1:0]     addr_out;
  logic           busy, done, err;

  calc_exec #(.W(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .recall_addr(recall_addr), .result_out(result_out), .func_out(func_out),
    .addr_out(addr_out), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Behavioural model: cycle k is the cycle following the k-th rising edge.
  int          cyc = 0;
  bit          m_active = 1'b0;
  int          m_wcyc = 0;
  logic [1:0]  m_op = 2'd0;
  logic [15:0] m_res = 16'd0, m_pend = 16'd0;
  bit          m_err = 1'b0, m_pend_err = 1'b0;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_active = 1'b0;
      m_res    = 16'd0;
      m_err    = 1'b0;
    end else begin
      if (m_active && m_wcyc == cyc - 1) begin
        m_active = 1'b0;
      end else if (!m_active && start) begin
        m_active = 1'b1;
        m_op     = op;
        m_err    = 1'b0;
        m_wcyc   = cyc + ((op < 2) ? 1 : W + 1) - 1;
        case (op)
          2'd0:    m_pend = 16'(int'(a) + int'(b));
          2'd1:    m_pend = 16'(int'(a) - int'(b));
          2'd2:    m_pend = 16'(int'(a) * int'(b));
          default: m_pend = (b == 0) ? {a, 8'hFF} : {8'(a % b), 8'(a / b)};
        endcase
        m_pend_err = (op == 2'd3) && (b == 0);
      end
      if (m_active && cyc == m_wcyc) begin
        m_res = m_pend;
        m_err = m_pend_err;
      end
    end
  end

  bit         chk_en = 1'b0;
  logic       e_done;
  logic [2:0] e_func;
  logic [1:0] e_addr;

  // Compare every output against the model once per cycle, mid-cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      e_done = m_active && (cyc == m_wcyc);
      e_func = e_done ? (3'(m_op) + 3'd1) : 3'd0;
      e_addr = e_done ? m_op : recall_addr;
      chk("model_busy",   32'(busy),       32'(m_active));
      chk("model_done",   32'(done),       32'(e_done));
      chk("model_func",   32'(func_out),   32'(e_func));
      chk("model_addr",   32'(addr_out),   32'(e_addr));
      chk("model_result", 32'(result_out), 32'(m_res));
      chk("model_err",    32'(err),        32'(m_err));
    end
  end

  // Raise start for one cycle; returns 2 ns into cycle N+1.
  task automatic start_op(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y);
    @(posedge clk); #2;
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #2;
    start = 1'b0;
    op = 2'($urandom); a = 8'($urandom); b = 8'($urandom);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = 2'd0; a = '0; b = '0; recall_addr = 2'd0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    chk_en = 1'b1;

    @(negedge clk);
    chk("reset_result", 32'(result_out), 32'h0);
    chk("reset_busy",   32'(busy),       32'h0);
    chk("reset_func",   32'(func_out),   32'h0);
    chk("reset_err",    32'(err),        32'h0);

    // add 200 + 100
    start_op(2'd0, 8'd200, 8'd100);
    @(negedge clk);
    chk("add_result", 32'(result_out), 32'h012C);
    chk("add_func",   32'(func_out),   32'h1);
    chk("add_addr",   32'(addr_out),   32'h0);
    chk("add_done",   32'(done),       32'h1);
    @(negedge clk);
    chk("add_func_after", 32'(func_out), 32'h0);

    // sub 5 - 9
    start_op(2'd1, 8'd5, 8'd9);
    @(negedge clk);
    chk("sub_result", 32'(result_out), 32'hFFFC);
    chk("sub_func",   32'(func_out),   32'h2);
    chk("sub_addr",   32'(addr_out),   32'h1);

    // mul 255 * 255
    start_op(2'd2, 8'd255, 8'd255);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      chk("mul_run_busy", 32'(busy),     32'h1);
      chk("mul_run_func", 32'(func_out), 32'h0);
    end
    @(negedge clk);
    chk("mul_result", 32'(result_out), 32'hFE01);
    chk("mul_func",   32'(func_out),   32'h3);
    chk("mul_busy",   32'(busy),       32'h1);

    // div 200 / 7
    start_op(2'd3, 8'd200, 8'd7);
    repeat (8) @(negedge clk);
    @(negedge clk);
    chk("div_result", 32'(result_out), 32'h041C);
    chk("div_err",    32'(err),        32'h0);

    // div by zero
    start_op(2'd3, 8'd42, 8'd0);
    repeat (8) @(negedge clk);
    @(negedge clk);
    chk("div0_result", 32'(result_out), 32'h2AFF);
    chk("div0_func",   32'(func_out),   32'h4);
    chk("div0_err",    32'(err),        32'h1);
    @(negedge clk);
    chk("div0_err_held", 32'(err), 32'h1);
    start_op(2'd0, 8'd1, 8'd1);
    @(negedge clk);
    chk("div0_err_clear", 32'(err), 32'h0);

    // reset mid-multiply, with start asserted alongside rst
    start_op(2'd2, 8'd13, 8'd11);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1; start = 1'b1; op = 2'd0;
    @(posedge clk); #2;
    rst = 1'b0; start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("abort_busy",   32'(busy),       32'h0);
      chk("abort_result", 32'(result_out), 32'h0);
      chk("abort_func",   32'(func_out),   32'h0);
    end
    start_op(2'd0, 8'd1, 8'd2);
    @(negedge clk);
    chk("post_reset_add", 32'(result_out), 32'h0003);

    // start pulses during RUN and WRITE are ignored
    start_op(2'd2, 8'd16, 8'd17);
    @(posedge clk); #2;
    @(posedge clk); #2;
    start = 1'b1; op = 2'd0; a = 8'd1; b = 8'd1;
    @(posedge clk); #2;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2 start = 1'b1;
    @(negedge clk);
    chk("ignore_func",   32'(func_out),   32'h3);
    chk("ignore_result", 32'(result_out), 32'h0110);
    @(posedge clk); #2;
    start = 1'b0;
    @(negedge clk);
    chk("ignore_idle_busy", 32'(busy),     32'h0);
    chk("ignore_idle_func", 32'(func_out), 32'h0);

    // recall while idle
    for (int r = 0; r < 4; r++) begin
      @(posedge clk); #2;
      recall_addr = 2'(r);
      @(negedge clk);
      chk("recall_addr", 32'(addr_out), 32'(r));
      chk("recall_func", 32'(func_out), 32'h0);
    end

    // randomized traffic, checked by the model every cycle
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk); #2;
      rst         = ($urandom_range(0, 80) == 0);
      start       = ($urandom_range(0, 2) == 0);
      op          = 2'($urandom);
      a           = 8'($urandom);
      b           = ($urandom_range(0, 6) == 0) ? 8'd0 : 8'($urandom);
      recall_addr = 2'($urandom);
    end
    @(posedge clk); #2;
    rst = 1'b0; start = 1'b0;
    repeat (12) @(posedge clk);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
